// File: rtl/bitcoin_nonce_scheduler.sv
// Steps the hash core through nonce batches, arbitrates the shared memory port,
// and scans each batch's result words against the difficulty target.
module bitcoin_nonce_scheduler #(
    parameter int NUM_NONCES = 16,
    parameter int BATCH_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        message_addr,
    input  logic [15:0]        result_addr,
    input  logic [BATCH_W-1:0] num_batches,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [31:0]        found_nonce,
    output logic [BATCH_W-1:0] batches_done,
    output logic               core_start,
    output logic [15:0]        core_message_addr,
    output logic [15:0]        core_output_addr,
    output logic [31:0]        core_nonce_base,
    input  logic               core_done,
    input  logic               core_mem_we,
    input  logic [15:0]        core_mem_addr,
    input  logic [31:0]        core_mem_write_data,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);

    localparam int CNT_W = $clog2(NUM_NONCES + 2);
    localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_NN1  = CNT_W'(NUM_NONCES - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_NONCES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_SCAN, S_FINISH} state_t;

    state_t             r_state;
    logic               r_done;
    logic               r_found;
    logic [31:0]        r_found_nonce;
    logic [BATCH_W-1:0] r_batches_done;
    logic [BATCH_W-1:0] r_num_batches;
    logic               r_core_start;
    logic [15:0]        r_message_addr;
    logic [15:0]        r_result_addr;
    logic [31:0]        r_target;
    logic [31:0]        r_nonce_base;
    logic               r_wait_first;
    logic [CNT_W-1:0]   r_scan_cnt;

    logic [15:0]        w_scan_addr;
    logic               w_hit;
    logic               w_last;
    logic [BATCH_W-1:0] w_bd_next;

    // Address holds on the last word during the two read-latency drain cycles.
    assign w_scan_addr = r_result_addr + 16'((r_scan_cnt > C_NN1) ? C_NN1 : r_scan_cnt);
    assign w_hit       = (r_state == S_SCAN) && (r_scan_cnt >= C_TWO) && (mem_read_data < r_target);
    assign w_last      = (r_scan_cnt == C_LAST);
    assign w_bd_next   = r_batches_done + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_done         <= 1'b1;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_batches_done <= '0;
            r_num_batches  <= '0;
            r_core_start   <= 1'b0;
            r_message_addr <= '0;
            r_result_addr  <= '0;
            r_target       <= '0;
            r_nonce_base   <= '0;
            r_wait_first   <= 1'b0;
            r_scan_cnt     <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b1;
                    if (start) begin
                        r_message_addr <= message_addr;
                        r_result_addr  <= result_addr;
                        r_num_batches  <= num_batches;
                        r_target       <= target;
                        r_found        <= 1'b0;
                        r_found_nonce  <= '0;
                        r_batches_done <= '0;
                        r_nonce_base   <= '0;
                        r_done         <= 1'b0;
                        if (num_batches == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state      <= S_LAUNCH;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_state      <= S_WAIT;
                    r_wait_first <= 1'b1;
                end
                S_WAIT: begin
                    // The core may still report idle on the cycle right after launch.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && core_done) begin
                        r_state    <= S_SCAN;
                        r_scan_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                    if (w_hit && !r_found) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_nonce_base + 32'(r_scan_cnt - C_TWO);
                    end
                    if (w_last) begin
                        r_batches_done <= w_bd_next;
                        if (r_found || w_hit || (w_bd_next == r_num_batches)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state      <= S_LAUNCH;
                            r_core_start <= 1'b1;
                            // Equivalent to batch_index*NUM_NONCES, kept as a running sum.
                            r_nonce_base <= r_nonce_base + 32'(NUM_NONCES);
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = w_scan_addr;
        mem_write_data = '0;
        if (r_state == S_LAUNCH || r_state == S_WAIT) begin
            mem_we         = core_mem_we;
            mem_addr       = core_mem_addr;
            mem_write_data = core_mem_write_data;
        end
    end

    assign done              = r_done;
    assign found             = r_found;
    assign found_nonce       = r_found_nonce;
    assign batches_done      = r_batches_done;
    assign core_start        = r_core_start;
    assign core_message_addr = r_message_addr;
    assign core_output_addr  = r_result_addr;
    assign core_nonce_base   = r_nonce_base;

endmodule

// File: tb/tb_bitcoin_nonce_scheduler.sv
// Bench for bitcoin_nonce_scheduler: model core + 2-cycle memory, results checked
// against a batch/index search over the hash table each core run writes.
module tb_bitcoin_nonce_scheduler;

    localparam int NN = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   message_addr, result_addr;
    logic [BW-1:0] num_batches;
    logic [31:0]   target;
    logic          done, found, core_start;
    logic [31:0]   found_nonce, core_nonce_base;
    logic [BW-1:0] batches_done;
    logic [15:0]   core_message_addr, core_output_addr;
    logic          core_done = 1'b1;
    logic          core_mem_we = 1'b0;
    logic [15:0]   core_mem_addr = '0;
    logic [31:0]   core_mem_write_data = '0;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    bitcoin_nonce_scheduler #(.NUM_NONCES(NN), .BATCH_W(BW)) dut (
        .clk(clk), .reset(rst), .start(start),
        .message_addr(message_addr), .result_addr(result_addr),
        .num_batches(num_batches), .target(target),
        .done(done), .found(found), .found_nonce(found_nonce), .batches_done(batches_done),
        .core_start(core_start), .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_nonce_base(core_nonce_base),
        .core_done(core_done), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
        .core_mem_write_data(core_mem_write_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Memory with two cycles of read latency.
    logic [31:0] mem [0:65535];
    logic [31:0] rd1, rd2;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        rd1 <= mem[mem_addr];
        rd2 <= rd1;
    end
    assign mem_read_data = rd2;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Hash words the model core writes: tab[batch][index].
    logic [31:0] tab [0:255][0:NN-1];
    logic [31:0] launch_q[$];
    logic [15:0] exp_msg, exp_out;
    bit          chk_en = 1'b1;
    int          c_ph = 0;
    int          c_i = 0;
    int          c_b = 0;
    logic [15:0] c_out = '0;
    bit          c_fin = 1'b0;
    bit          c_junk = 1'b0;
    int          n_starts = 0;

    // Model core: drops core_done two cycles after launch, writes NN words, then
    // idles while driving a stray write that the scheduler must block.
    always @(negedge clk) begin
        if (core_start) n_starts <= n_starts + 1;
        if (chk_en && c_ph == 3) begin
            chk("mirror_we", mem_we, core_mem_we);
            chk("mirror_addr", mem_addr, core_mem_addr);
            chk("mirror_data", mem_write_data, core_mem_write_data);
        end else if (chk_en && c_ph == 0 && c_junk && !core_start) begin
            chk("block_we", mem_we, 0);
            chk("block_data", mem_write_data, 0);
        end
        case (c_ph)
            0: if (core_start) begin
                   c_ph <= 1; c_junk <= 1'b0; core_mem_we <= 1'b0;
                   c_b <= int'((core_nonce_base / NN) & 32'hFF);
                   c_out <= core_output_addr;
                   launch_q.push_back(core_nonce_base);
                   if (chk_en) begin
                       chk("core_msg_addr", core_message_addr, exp_msg);
                       chk("core_out_addr", core_output_addr, exp_out);
                   end
               end else if (c_fin) begin
                   c_fin <= 1'b0; c_junk <= 1'b1;
                   core_mem_we <= 1'b1; core_mem_addr <= c_out;
                   core_mem_write_data <= 32'h0BAD_F00D;
               end
            1: c_ph <= 2;
            2: begin
                   c_ph <= 3; c_i <= 0; core_done <= 1'b0;
                   core_mem_we <= 1'b1; core_mem_addr <= c_out;
                   core_mem_write_data <= tab[c_b][0];
               end
            default: if (c_i == NN - 1) begin
                   c_ph <= 0; core_done <= 1'b1; core_mem_we <= 1'b0; c_fin <= 1'b1;
               end else begin
                   c_i <= c_i + 1;
                   core_mem_addr <= c_out + 16'(c_i + 1);
                   core_mem_write_data <= tab[c_b][c_i + 1];
               end
        endcase
    end

    task automatic fill(input int nb, input logic [31:0] tg, input int pct);
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < NN; i++) begin
                tab[b][i] = $urandom | 32'h8000_0000;
                if (tg != 0 && $urandom_range(0, 99) < pct) tab[b][i] = $urandom_range(0, tg - 1);
                else if ($urandom_range(0, 19) == 0) tab[b][i] = tg;
            end
    endtask

    task automatic run(input string tag, input logic [BW-1:0] nb, input logic [31:0] tg,
                       input logic [15:0] ra, output int lows);
        bit ef; logic [31:0] en; int ebd; int cyc; int bad;
        ef = 0; en = 0; ebd = int'(nb);
        for (int b = 0; b < int'(nb); b++)
            for (int i = 0; i < NN; i++)
                if (!ef && tab[b][i] < tg) begin ef = 1; en = 32'(b * NN + i); ebd = b + 1; end
        @(posedge clk); #1;
        message_addr = 16'($urandom); result_addr = ra; num_batches = nb; target = tg;
        exp_msg = message_addr; exp_out = ra; launch_q.delete(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lows = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 200 + int'(nb) * 60) begin
            lows++;
            @(posedge clk); #1;
            cyc++;
            // c_fin is high only in the first scan cycle: poke start and scramble inputs.
            start = c_fin;
            if (c_fin) begin
                num_batches = BW'($urandom); target = $urandom; result_addr = 16'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, ":done"}, done, 1);
        chk({tag, ":found"}, found, ef);
        chk({tag, ":nonce"}, found_nonce, en);
        chk({tag, ":batches"}, batches_done, 32'(ebd));
        chk({tag, ":launches"}, launch_q.size(), 32'(ebd));
        bad = 0;
        foreach (launch_q[k]) if (launch_q[k] !== 32'(k * NN)) bad++;
        chk({tag, ":bases"}, bad, 0);
    endtask

    int lows;
    int cyc;
    int s0;

    initial begin
        rst = 1'b1; start = 1'b0; message_addr = '0; result_addr = '0;
        num_batches = '0; target = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:done", done, 1);
        chk("rst:found", found, 0);
        chk("rst:nonce", found_nonce, 0);
        chk("rst:batches", batches_done, 0);
        chk("rst:core_start", core_start, 0);
        chk("rst:base", core_nonce_base, 0);
        chk("rst:msg", core_message_addr, 0);
        chk("rst:out", core_output_addr, 0);
        chk("rst:mem_we", mem_we, 0);
        rst = 1'b0;

        run("zero", 0, 32'hFFFF_FFFF, 16'h0100, lows);
        chk("zero:low_cycles", lows, 2);

        for (int b = 0; b < 3; b++) for (int i = 0; i < NN; i++) tab[b][i] = 32'h1;
        run("t0", 3, 32'h0, 16'h0200, lows);

        for (int b = 0; b < 4; b++)
            for (int i = 0; i < NN; i++) tab[b][i] = 32'h1000 + $urandom_range(0, 1000);
        tab[0][3] = 32'h1000;
        tab[1][5] = 32'h0FFF;
        tab[1][9] = 32'h0FFF;
        run("win", 4, 32'h1000, 16'h0300, lows);
        chk("win:nonce21", found_nonce, 21);

        fill(1, 32'h0, 0);
        tab[0][7] = 32'h0FF;
        run("wrap", 1, 32'h100, 16'hFFFA, lows);
        chk("wrap:mem0001", mem[16'h0001], 32'h0FF);

        // Reset while the core is mid-run.
        fill(2, 32'h0, 0);
        @(posedge clk); #1;
        num_batches = 2; target = 0; result_addr = 16'h0400; message_addr = 16'h1234;
        exp_msg = 16'h1234; exp_out = 16'h0400; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0;
        while (c_ph != 3 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("mid:core_busy", c_ph, 3);
        chk_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid:done", done, 1);
        chk("mid:core_start", core_start, 0);
        chk("mid:mem_we", mem_we, 0);
        chk("mid:found", found, 0);
        @(posedge clk); #1;
        rst = 1'b0; s0 = n_starts;
        repeat (40) @(posedge clk);
        #1;
        chk("mid:no_launch", n_starts - s0, 0);
        chk("mid:idle", done, 1);
        cyc = 0;
        while (c_ph != 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk_en = 1'b1;

        for (int r = 0; r < 10; r++) begin
            logic [BW-1:0] nb; logic [31:0] tg;
            nb = BW'($urandom_range(0, 6));
            tg = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom_range(1, 32'h7FFF_FFFF);
            fill(int'(nb), tg, 3);
            run("rand", nb, tg, 16'($urandom), lows);
        end

        fill(255, 32'h0, 0);
        run("full", 8'hFF, 32'h0, 16'hFF00, lows);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
